// File: rtl/trigger_conditioner.sv
// trigger_conditioner
// Conditions the raw, asynchronous target trigger pin into a clean single-cycle
// strobe for the glitch pulser. The chain is: synchroniser, glitch filter,
// selectable edge detect, Nth-edge counter and a post-fire holdoff window.
// All configuration inputs are expected to be static for the duration of a run.

module trigger_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_WIDTH  = 8,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger_i,
  input  logic                     en_i,
  input  logic [1:0]               edge_sel_i,
  input  logic [FILTER_WIDTH-1:0]  filter_len_i,
  input  logic [7:0]               edge_count_i,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
  output logic                     trigger_o,
  output logic                     level_o,
  output logic [7:0]               edge_cnt_o,
  output logic                     holdoff_o
);

  // Controller states. Any other encoding falls back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COUNT   = 2'b01,
    ST_HOLDOFF = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // Shift the raw pin through SYNC_STAGES flops to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_i};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Glitch filter
  // ---------------------------------------------------------------------------
  // The filtered level only follows sync_out once it has disagreed with the
  // current filtered level for filter_len_i + 1 consecutive cycles. The >=
  // comparison means shrinking filter_len_i while a count is in progress can
  // never strand the counter above the threshold.
  logic                    filt;
  logic                    filt_d;
  logic [FILTER_WIDTH-1:0] mcnt;

  // Mismatch counter and filtered level; runs regardless of en_i or FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt   <= 1'b0;
      filt_d <= 1'b0;
      mcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (sync_out == filt) begin
        mcnt <= '0;
      end else if (mcnt >= filter_len_i) begin
        filt <= sync_out;
        mcnt <= '0;
      end else begin
        mcnt <= mcnt + 1'b1;
      end
    end
  end

  assign level_o = filt;

  // ---------------------------------------------------------------------------
  // Edge qualification
  // ---------------------------------------------------------------------------
  logic rise;
  logic fall;
  logic qual;

  assign rise = filt & ~filt_d;
  assign fall = ~filt & filt_d;
  assign qual = (edge_sel_i[0] & rise) | (edge_sel_i[1] & fall);

  // ---------------------------------------------------------------------------
  // Nth-edge counter and holdoff controller
  // ---------------------------------------------------------------------------
  state_t                   state;
  state_t                   state_n;
  logic [7:0]               ecnt;
  logic [7:0]               ecnt_n;
  logic [HOLDOFF_WIDTH-1:0] hcnt;
  logic [HOLDOFF_WIDTH-1:0] hcnt_n;
  logic                     trig_n;

  // An edge count of zero behaves as one so the block always fires eventually.
  logic [7:0] n_eff;
  logic [8:0] ecnt_inc;
  logic       nth_hit;

  assign n_eff    = (edge_count_i == 8'd0) ? 8'd1 : edge_count_i;
  assign ecnt_inc = {1'b0, ecnt} + 9'd1;
  assign nth_hit  = (ecnt_inc >= {1'b0, n_eff});

  // State, counters and the registered strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ecnt      <= 8'd0;
      hcnt      <= '0;
      trigger_o <= 1'b0;
    end else begin
      state     <= state_n;
      ecnt      <= ecnt_n;
      hcnt      <= hcnt_n;
      trigger_o <= trig_n;
    end
  end

  // Next-state logic; dropping en_i wins over everything, including an edge.
  always_comb begin
    state_n = state;
    ecnt_n  = ecnt;
    hcnt_n  = hcnt;
    trig_n  = 1'b0;

    if (!en_i) begin
      state_n = ST_IDLE;
      ecnt_n  = 8'd0;
      hcnt_n  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_COUNT;
          ecnt_n  = 8'd0;
          hcnt_n  = '0;
        end

        ST_COUNT: begin
          if (qual) begin
            if (nth_hit) begin
              trig_n  = 1'b1;
              ecnt_n  = 8'd0;
              hcnt_n  = '0;
              state_n = ST_HOLDOFF;
            end else if (ecnt != 8'hFF) begin
              ecnt_n = ecnt + 8'd1;
            end
          end
        end

        ST_HOLDOFF: begin
          if (hcnt == holdoff_i) begin
            state_n = ST_COUNT;
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end

        default: begin
          state_n = ST_IDLE;
          ecnt_n  = 8'd0;
          hcnt_n  = '0;
        end
      endcase
    end
  end

  assign edge_cnt_o = ecnt;
  assign holdoff_o  = (state == ST_HOLDOFF);

endmodule

// File: tb/tb_trigger_conditioner.sv
// tb_trigger_conditioner
// Directed scenarios plus randomized trigger waveforms, checked every cycle
// against a run-length / countdown reference model of the conditioner.

module tb_trigger_conditioner;

  localparam int S  = 2;
  localparam int FW = 8;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          trigger_i;
  logic          en_i;
  logic [1:0]    edge_sel_i;
  logic [FW-1:0] filter_len_i;
  logic [7:0]    edge_count_i;
  logic [HW-1:0] holdoff_i;
  logic          trigger_o;
  logic          level_o;
  logic [7:0]    edge_cnt_o;
  logic          holdoff_o;

  int total = 0;
  int bad   = 0;

  trigger_conditioner #(
    .SYNC_STAGES  (S),
    .FILTER_WIDTH (FW),
    .HOLDOFF_WIDTH(HW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger_i   (trigger_i),
    .en_i        (en_i),
    .edge_sel_i  (edge_sel_i),
    .filter_len_i(filter_len_i),
    .edge_count_i(edge_count_i),
    .holdoff_i   (holdoff_i),
    .trigger_o   (trigger_o),
    .level_o     (level_o),
    .edge_cnt_o  (edge_cnt_o),
    .holdoff_o   (holdoff_o)
  );

  always #5 clk = ~clk;

  // Reference model state: a pin history for the synchroniser, a run length of
  // disagreeing cycles for the filter, and an active flag / edge tally /
  // remaining-holdoff countdown for the controller.
  int m_sync [S];
  int m_filt;
  int m_filt_d;
  int m_run;
  int m_active;
  int m_edges;
  int m_hold;
  int m_trig;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic modelStep();
    int q;
    int nn;
    int so;
    if (rst) begin
      for (int i = 0; i < S; i++) m_sync[i] = 0;
      m_filt = 0; m_filt_d = 0; m_run = 0;
      m_active = 0; m_edges = 0; m_hold = 0; m_trig = 0;
    end else begin
      q = ((edge_sel_i[0] && m_filt == 1 && m_filt_d == 0) ||
           (edge_sel_i[1] && m_filt == 0 && m_filt_d == 1)) ? 1 : 0;
      nn = (edge_count_i == 8'd0) ? 1 : int'(edge_count_i);
      m_trig = 0;
      if (!en_i) begin
        m_active = 0; m_edges = 0; m_hold = 0;
      end else if (m_active == 0) begin
        m_active = 1; m_edges = 0; m_hold = 0;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (q == 1) begin
        if (m_edges + 1 >= nn) begin
          m_trig  = 1;
          m_edges = 0;
          m_hold  = int'(holdoff_i) + 1;
        end else begin
          m_edges = (m_edges + 1 > 255) ? 255 : m_edges + 1;
        end
      end

      so = m_sync[S-1];
      m_filt_d = m_filt;
      if (so != m_filt) begin
        m_run++;
        if (m_run >= int'(filter_len_i) + 1) begin
          m_filt = so;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end

      for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = int'(trigger_i);
    end
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("trigger_o",  32'(trigger_o),  32'(m_trig));
    checkOutput("level_o",    32'(level_o),    32'(m_filt));
    checkOutput("edge_cnt_o", 32'(edge_cnt_o), 32'(m_edges));
    checkOutput("holdoff_o",  32'(holdoff_o),  (m_hold > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic applyStimulus(input logic trig, input logic en);
    trigger_i = trig;
    en_i      = en;
    runCycle();
  endtask

  int lat;
  int seen_trig;
  int seen_lvl;
  int fires;
  int hold_left;
  logic lvl;

  initial begin
    rst          = 1'b1;
    trigger_i    = 1'b0;
    en_i         = 1'b0;
    edge_sel_i   = 2'b01;
    filter_len_i = '0;
    edge_count_i = 8'd1;
    holdoff_i    = '0;
    lvl          = 1'b0;

    // Reset
    for (int i = 0; i < 3; i++) runCycle();
    checkOutput("reset_trigger_o",  32'(trigger_o),  32'd0);
    checkOutput("reset_level_o",    32'(level_o),    32'd0);
    checkOutput("reset_edge_cnt_o", 32'(edge_cnt_o), 32'd0);
    checkOutput("reset_holdoff_o",  32'(holdoff_o),  32'd0);
    rst = 1'b0;

    // Scenario 1: L=0, N=1, H=0 rising edge latency of S+L+1 = 3
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 1'b1);
      if (trigger_o === 1'b1 && lat < 0) lat = c;
    end
    checkOutput("latency_L0", 32'(lat), 32'd3);
    checkOutput("level_high", 32'(level_o), 32'd1);

    // Scenario 2: L=4, short glitch rejected, long pulse accepted
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
    filter_len_i = 8'd4;
    seen_trig = 0;
    seen_lvl  = 0;
    for (int c = 0; c < 25; c++) begin
      applyStimulus((c < 3) ? 1'b1 : 1'b0, 1'b1);
      if (trigger_o === 1'b1) seen_trig = 1;
      if (level_o === 1'b1) seen_lvl = 1;
    end
    checkOutput("glitch_trigger", 32'(seen_trig), 32'd0);
    checkOutput("glitch_level",   32'(seen_lvl),  32'd0);
    lat = -1;
    for (int c = 0; c < 25; c++) begin
      applyStimulus((c < 5) ? 1'b1 : 1'b0, 1'b1);
      if (trigger_o === 1'b1 && lat < 0) lat = c;
    end
    checkOutput("latency_L4", 32'(lat), 32'd7);

    // Scenario 3: both edges, every 3rd edge fires
    applyStimulus(1'b0, 1'b0);
    edge_sel_i   = 2'b11;
    edge_count_i = 8'd3;
    holdoff_i    = '0;
    filter_len_i = '0;
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1);
    fires = 0;
    for (int c = 0; c < 135; c++) begin
      applyStimulus((c < 120 && (c % 20) < 10) ? 1'b1 : 1'b0, 1'b1);
      if (trigger_o === 1'b1) fires++;
    end
    checkOutput("square_fires", 32'(fires), 32'd4);

    // Scenario 4: long holdoff swallows closely spaced rising edges
    applyStimulus(1'b0, 1'b0);
    edge_sel_i   = 2'b01;
    edge_count_i = 8'd1;
    holdoff_i    = 16'd50;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    fires = 0;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(((c % 10) < 5) ? 1'b1 : 1'b0, 1'b1);
      if (trigger_o === 1'b1) fires++;
    end
    checkOutput("holdoff_fires", 32'(fires), 32'd2);

    // Randomized segments; config only changes while disabled
    for (int seg = 0; seg < 16; seg++) begin
      applyStimulus(lvl, 1'b0);
      edge_sel_i   = 2'($urandom_range(0, 3));
      filter_len_i = 8'($urandom_range(0, 5));
      edge_count_i = 8'($urandom_range(0, 4));
      holdoff_i    = 16'($urandom_range(0, 30));
      hold_left    = 0;
      for (int c = 0; c < 300; c++) begin
        if (hold_left == 0) begin
          lvl       = 1'($urandom_range(0, 1));
          hold_left = $urandom_range(1, 12);
        end
        hold_left--;
        applyStimulus(lvl, ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
